// File: rtl/jtag_dbg_dr_unit.sv
// Debug data-register unit behind the JTAG TAP: shifts DR scans, turns each Update-DR
// into one req/ack bus transfer, and reports status/read data on the next capture.
module jtag_dbg_dr_unit #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  tap_tck,
  input  logic                  jtag_trstn,
  input  logic                  tap_TestLogicReset,
  input  logic                  tap_CaptureDR,
  input  logic                  tap_ShiftDR,
  input  logic                  tap_UpdateDR,
  input  logic                  dbg_sel,
  input  logic                  dbg_tdi,
  output logic                  dbg_tdo,
  output logic                  dbg_req,
  output logic                  dbg_we,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_ack,
  input  logic                  dbg_err,
  input  logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int unsigned DR_LEN = 4 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, REQ} state_e;

  state_e                state_q, state_d;
  logic [DR_LEN-1:0]     sr_q, sr_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  overrun_q, overrun_d;
  logic                  bus_err_q, bus_err_d;

  logic [3:0] cmd;
  logic [3:0] status;
  logic       upd;
  logic       rw_cmd;

  assign cmd     = sr_q[3:0];
  assign upd     = dbg_sel & tap_UpdateDR;
  assign rw_cmd  = upd & ((cmd == 4'h1) | (cmd == 4'h2));
  assign status  = {timeout_q, overrun_q, bus_err_q, (state_q == REQ)};

  assign dbg_tdo   = sr_q[0];
  assign dbg_req   = req_q;
  assign dbg_we    = we_q;
  assign dbg_addr  = addr_q;
  assign dbg_wdata = wdata_q;

  // Next-state: clears are applied before sticky sets so a coincident set wins.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    last_addr_d = last_addr_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
    bus_err_d   = bus_err_q;

    if (dbg_sel && tap_CaptureDR) begin
      sr_d = {rdata_q, last_addr_q, status};
    end else if (dbg_sel && tap_ShiftDR) begin
      sr_d = {dbg_tdi, sr_q[DR_LEN-1:1]};
    end

    if (upd && (cmd == 4'h3)) begin
      timeout_d = 1'b0;
      overrun_d = 1'b0;
      bus_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rw_cmd) begin
          req_d       = 1'b1;
          we_d        = cmd[1];
          addr_d      = sr_q[4 +: ADDR_WIDTH];
          wdata_d     = sr_q[4 + ADDR_WIDTH +: DATA_WIDTH];
          last_addr_d = sr_q[4 +: ADDR_WIDTH];
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (rw_cmd) begin
          overrun_d = 1'b1;
        end
        // Ack takes priority over an expiring timeout on the same edge.
        if (dbg_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (dbg_err) begin
            bus_err_d = 1'b1;
          end else if (!we_q) begin
            rdata_d = dbg_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (tap_TestLogicReset) begin
      state_d     = IDLE;
      sr_d        = '0;
      req_d       = 1'b0;
      we_d        = 1'b0;
      addr_d      = '0;
      wdata_d     = '0;
      rdata_d     = '0;
      last_addr_d = '0;
      cnt_d       = '0;
      timeout_d   = 1'b0;
      overrun_d   = 1'b0;
      bus_err_d   = 1'b0;
    end
  end

  always_ff @(posedge tap_tck or negedge jtag_trstn) begin
    if (!jtag_trstn) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      last_addr_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      last_addr_q <= last_addr_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      bus_err_q   <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_jtag_dbg_dr_unit.sv
// Bench for jtag_dbg_dr_unit: directed scans with literal expectations plus random
// scans, all outputs compared every cycle against a transaction-level model.
module tb_jtag_dbg_dr_unit;

  localparam int A  = 16;
  localparam int D  = 32;
  localparam int T  = 4;
  localparam int DL = 4 + A + D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tlr, cap_s, shift_s, upd_s, sel, tdi;
  logic          dbg_tdo, dbg_req, dbg_we;
  logic [A-1:0]  dbg_addr;
  logic [D-1:0]  dbg_wdata;
  logic          dbg_ack, dbg_err;
  logic [D-1:0]  dbg_rdata;

  int checks = 0;
  int errors = 0;

  int            resp_lat;   // ack on this cycle of a request; 0 = never ack
  logic          resp_err;
  logic [D-1:0]  resp_rdata;
  int            r_age;

  jtag_dbg_dr_unit #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .TIMEOUT_CYCLES(T)) dut (
    .tap_tck(clk), .jtag_trstn(rst_n), .tap_TestLogicReset(tlr),
    .tap_CaptureDR(cap_s), .tap_ShiftDR(shift_s), .tap_UpdateDR(upd_s),
    .dbg_sel(sel), .dbg_tdi(tdi), .dbg_tdo(dbg_tdo),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  logic          mq[$];      // DR contents, element 0 is the bit on TDO
  logic          m_req, m_we, m_to, m_ov, m_be;
  logic [A-1:0]  m_addr, m_last;
  logic [D-1:0]  m_wdata, m_rdata;
  int            m_age;
  logic [DL-1:0] m_snap, m_vec;
  logic [3:0]    m_cmd, m_stat;
  logic          m_upd, m_rw, m_was;

  function automatic void m_clear();
    mq.delete();
    for (int i = 0; i < DL; i++) mq.push_back(1'b0);
    m_req = 0; m_we = 0; m_to = 0; m_ov = 0; m_be = 0;
    m_addr = '0; m_last = '0; m_wdata = '0; m_rdata = '0; m_age = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || tlr) begin
      m_clear();
    end else begin
      for (int i = 0; i < DL; i++) m_snap[i] = mq[i];
      m_cmd  = m_snap[3:0];
      m_upd  = sel && upd_s;
      m_rw   = m_upd && (m_cmd == 4'd1 || m_cmd == 4'd2);
      m_was  = m_req;
      m_stat = {m_to, m_ov, m_be, m_req};
      if (sel && cap_s) begin
        m_vec = {m_rdata, m_last, m_stat};
        mq.delete();
        for (int i = 0; i < DL; i++) mq.push_back(m_vec[i]);
      end else if (sel && shift_s) begin
        void'(mq.pop_front());
        mq.push_back(tdi);
      end
      if (m_upd && m_cmd == 4'd3) begin
        m_to = 0; m_ov = 0; m_be = 0;
      end
      if (m_was) begin
        if (m_rw) m_ov = 1;
        m_age++;
        if (dbg_ack) begin
          m_req = 0;
          if (dbg_err) m_be = 1;
          else if (!m_we) m_rdata = dbg_rdata;
        end else if (m_age == T) begin
          m_req = 0;
          m_to  = 1;
        end
      end else if (m_rw) begin
        m_req = 1; m_age = 0;
        m_we = (m_cmd == 4'd2);
        m_addr = m_snap[19:4]; m_last = m_snap[19:4]; m_wdata = m_snap[51:20];
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("req",   64'(dbg_req),   64'(m_req));
    chk("tdo",   64'(dbg_tdo),   64'(mq[0]));
    chk("we",    64'(dbg_we),    64'(m_we));
    chk("addr",  64'(dbg_addr),  64'(m_addr));
    chk("wdata", 64'(dbg_wdata), 64'(m_wdata));
  end

  // Bus responder
  always @(negedge clk) begin
    if (!dbg_req) begin
      r_age   = 0;
      dbg_ack = 1'b0;
    end else begin
      r_age++;
      dbg_ack = (resp_lat != 0) && (r_age == resp_lat);
    end
    dbg_err   = resp_err;
    dbg_rdata = resp_rdata;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scan(input logic s, input logic do_cap, input logic [DL-1:0] din,
                      output logic [DL-1:0] dout);
    sel = s;
    if (do_cap) begin
      cap_s = 1'b1;
      step();
      cap_s = 1'b0;
    end
    for (int i = 0; i < DL; i++) begin
      shift_s = 1'b1;
      tdi     = din[i];
      dout[i] = dbg_tdo;
      step();
    end
    shift_s = 1'b0;
    upd_s   = 1'b1;
    step();
    upd_s   = 1'b0;
    sel     = 1'b0;
  endtask

  task automatic pulse_update();
    sel = 1'b1; upd_s = 1'b1;
    step();
    upd_s = 1'b0; sel = 1'b0;
  endtask

  task automatic pulse_tlr();
    tlr = 1'b1;
    step();
    tlr = 1'b0;
  endtask

  task automatic count_req(output int n);
    n = 0;
    for (int k = 0; k < 100 && dbg_req; k++) begin
      n++;
      step();
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && dbg_req; k++) step();
    chk("idle_wait", 64'(dbg_req), 64'(0));
  endtask

  logic [DL-1:0] d;
  logic [DL-1:0] pat;
  int            n;
  int            r;
  logic [3:0]    rc;

  initial begin
    m_clear();
    rst_n = 1'b0; tlr = 0; cap_s = 0; shift_s = 0; upd_s = 0; sel = 0; tdi = 0;
    resp_lat = 0; resp_err = 0; resp_rdata = '0;
    pat = {32'hA5A5A5A5, 16'h1234, 4'h0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_req", 64'(dbg_req), 64'(0));
    scan(1, 1, '0, d);
    chk("reset_scan", 64'(d), 64'(0));

    // write, acked on the third request cycle
    resp_lat = 3;
    scan(1, 1, {32'hDEADBEEF, 16'h0040, 4'h2}, d);
    chk("wr_req",   64'(dbg_req),   64'(1));
    chk("wr_we",    64'(dbg_we),    64'(1));
    chk("wr_addr",  64'(dbg_addr),  64'(16'h0040));
    chk("wr_wdata", 64'(dbg_wdata), 64'(32'hDEADBEEF));
    count_req(n);
    chk("wr_len", 64'(n), 64'(3));
    scan(1, 1, '0, d);
    chk("wr_status", 64'(d[3:0]),  64'(0));
    chk("wr_laddr",  64'(d[19:4]), 64'(16'h0040));

    // read
    resp_lat = 2; resp_rdata = 32'h12345678;
    scan(1, 1, {32'h0, 16'h0010, 4'h1}, d);
    wait_idle();
    scan(1, 1, '0, d);
    chk("rd_status", 64'(d[3:0]),   64'(0));
    chk("rd_data",   64'(d[51:20]), 64'(32'h12345678));

    // overrun while busy, then clear
    resp_lat = 0;
    scan(1, 1, {32'h11111111, 16'h0041, 4'h2}, d);
    pulse_update();
    scan(1, 1, '0, d);
    chk("ov_status", 64'(d[3:0]), 64'(4'b0101));
    wait_idle();
    scan(1, 1, {32'h0, 16'h0, 4'h3}, d);
    scan(1, 1, '0, d);
    chk("clr_status", 64'(d[3:0]), 64'(0));

    // timeout with no ack
    resp_lat = 0;
    scan(1, 1, {32'h0, 16'h0050, 4'h1}, d);
    count_req(n);
    chk("to_len", 64'(n), 64'(4));
    scan(1, 1, {32'h0, 16'h0, 4'h3}, d);
    chk("to_status", 64'(d[3:0]), 64'(4'b1000));

    // ack on the final allowed cycle beats the timeout
    resp_lat = 4; resp_rdata = 32'hCAFEF00D;
    scan(1, 1, {32'h0, 16'h0055, 4'h1}, d);
    count_req(n);
    chk("late_len", 64'(n), 64'(4));
    scan(1, 1, '0, d);
    chk("late_status", 64'(d[3:0]),   64'(0));
    chk("late_data",   64'(d[51:20]), 64'(32'hCAFEF00D));

    // bus error keeps old read data
    resp_lat = 2; resp_err = 1; resp_rdata = 32'h0BADBAD0;
    scan(1, 1, {32'h0, 16'h0060, 4'h1}, d);
    wait_idle();
    resp_err = 0;
    scan(1, 1, pat, d);
    chk("err_status", 64'(d[3:0]),   64'(4'b0010));
    chk("err_data",   64'(d[51:20]), 64'(32'hCAFEF00D));
    chk("err_laddr",  64'(d[19:4]),  64'(16'h0060));

    // deselected scan leaves DR untouched and issues nothing
    scan(0, 1, {32'hFFFFFFFF, 16'hFFFF, 4'h2}, d);
    chk("gate_req", 64'(dbg_req), 64'(0));
    scan(1, 0, {32'h0, 16'h0, 4'h3}, d);
    chk("gate_dr", 64'(d), 64'(pat));
    scan(1, 1, '0, d);
    chk("gate_status", 64'(d[3:0]), 64'(0));

    // async reset in the middle of a request
    resp_lat = 0;
    scan(1, 1, {32'h77777777, 16'h0070, 4'h2}, d);
    step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_req", 64'(dbg_req), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    scan(1, 1, '0, d);
    chk("arst_scan", 64'(d), 64'(0));

    // random traffic, checked every cycle by the model
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       rc = 4'h2;
      else if (r < 7)  rc = 4'h1;
      else if (r == 7) rc = 4'h3;
      else if (r == 8) rc = 4'($urandom_range(0, 15));
      else             rc = 4'h0;
      resp_lat   = int'($urandom_range(0, 6));
      resp_err   = ($urandom_range(0, 3) == 0);
      resp_rdata = $urandom;
      scan(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           {32'($urandom), 16'($urandom), rc}, d);
      if ($urandom_range(0, 3) == 0) pulse_update();
      if ($urandom_range(0, 7) == 0) pulse_tlr();
      repeat ($urandom_range(0, 8)) step();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
